// File: rtl/dump_hex_formatter.sv
// Converts a stream of raw dump bytes into uppercase ASCII hex text, two characters
// per byte, with CR LF after every BYTES_PER_LINE bytes or after the last byte of a dump.
module dump_hex_formatter #(
  parameter int BYTES_PER_LINE = 4
) (
  input  logic       comm_clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    CR   = 3'd3,
    LF   = 3'd4
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(BYTES_PER_LINE - 1);

  state_t     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       eol;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_q      <= 8'h00;
      last_q      <= 1'b0;
      cnt_q       <= 8'h00;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // All outputs are registered from next-state values, so handshake inputs never
  // reach in_ready/out_valid/out_data combinationally.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    eol        = (cnt_q == LAST_IDX) || last_q;
    out_data_d = 8'h00;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          byte_d  = in_data;
          last_d  = in_last;
          state_d = HI;
        end
      end
      HI: begin
        if (out_ready) state_d = LO;
      end
      LO: begin
        if (out_ready) begin
          if (eol) begin
            cnt_d   = 8'h00;
            state_d = CR;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = IDLE;
          end
        end
      end
      CR: begin
        if (out_ready) state_d = LF;
      end
      LF: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d != IDLE);

    case (state_d)
      HI:      out_data_d = hex_char(byte_d[7:4]);
      LO:      out_data_d = hex_char(byte_d[3:0]);
      CR:      out_data_d = 8'h0D;
      LF:      out_data_d = 8'h0A;
      default: out_data_d = 8'h00;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_dump_hex_formatter.sv
// Directed bench for dump_hex_formatter: one instance with 4 bytes per line, one with 1.
module tb_dump_hex_formatter;

  logic       comm_clock;
  logic       reset;
  logic       iv4, iv1;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;
  logic       ir4, ir1, ov4, ov1;
  logic [7:0] od4, od1;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [7:0] q4[$];
  logic [7:0] q1[$];
  logic [7:0] exp_q[$];

  dump_hex_formatter #(.BYTES_PER_LINE(4)) dut4 (
    .comm_clock(comm_clock), .reset(reset),
    .in_valid(iv4), .in_ready(ir4), .in_data(in_data), .in_last(in_last),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4)
  );

  dump_hex_formatter #(.BYTES_PER_LINE(1)) dut1 (
    .comm_clock(comm_clock), .reset(reset),
    .in_valid(iv1), .in_ready(ir1), .in_data(in_data), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1)
  );

  initial begin
    comm_clock = 1'b0;
    forever #5 comm_clock = ~comm_clock;
  end

  always @(posedge comm_clock) cyc <= cyc + 1;

  // Record every completed output transfer.
  always @(negedge comm_clock) begin
    if (!reset) begin
      if (ov4 && out_ready) q4.push_back(od4);
      if (ov1 && out_ready) q1.push_back(od1);
    end
  end

  function automatic logic rdy(input bit sel1);
    return sel1 ? ir1 : ir4;
  endfunction

  task automatic send(input bit sel1, input logic [7:0] b, input logic last, output int t);
    int n;
    n = 0;
    while (!rdy(sel1) && n < 200) begin
      @(posedge comm_clock); #1;
      n++;
    end
    if (n >= 200) begin
      vectors++; errors++;
      $display("FAIL send_timeout in_ready stuck 0 for byte %02h", b);
    end
    in_data = b;
    in_last = last;
    if (sel1) iv1 = 1'b1; else iv4 = 1'b1;
    @(posedge comm_clock); #1;
    t = cyc;
    iv1 = 1'b0;
    iv4 = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle(input bit sel1);
    int n;
    n = 0;
    while (!(rdy(sel1) && !(sel1 ? ov1 : ov4)) && n < 200) begin
      @(posedge comm_clock); #1;
      n++;
    end
    vectors++;
    if (n >= 200) begin
      errors++;
      $display("FAIL idle_timeout did not return to IDLE within %0d cycles", n);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge comm_clock); @(posedge comm_clock); #1;
    reset = 1'b0;
    @(posedge comm_clock); #1;
    q4.delete();
    q1.delete();
  endtask

  task automatic test_reset();
    @(posedge comm_clock); #1;
    vectors++; if (ir4 !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", ir4); end
    vectors++; if (ov4 !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", ov4); end
    vectors++; if (od4 !== 8'h00) begin errors++; $display("FAIL rst_out_data got %02h want 00", od4); end
    vectors++; if (ov1 !== 1'b0) begin errors++; $display("FAIL rst_out_valid1 got %b want 0", ov1); end
    reset = 1'b0;
    @(posedge comm_clock); #1;
    vectors++; if (ir4 !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", ir4); end
    vectors++; if (ir1 !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready1 got %b want 1", ir1); end
    vectors++; if (ov4 !== 1'b0) begin errors++; $display("FAIL rst_release_out_valid got %b want 0", ov4); end
  endtask

  task automatic test_line();
    int t0, t1, t2, t3;
    apply_reset();
    out_ready = 1'b1;
    send(0, 8'hDE, 0, t0);
    send(0, 8'hAD, 0, t1);
    send(0, 8'hBE, 0, t2);
    send(0, 8'hEF, 0, t3);
    wait_idle(0);
    exp_q = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    vectors++;
    if (q4.size() != exp_q.size()) begin errors++; $display("FAIL line_len got %0d want %0d", q4.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q4.size(); i++) begin
      vectors++;
      if (q4[i] !== exp_q[i]) begin errors++; $display("FAIL line_char[%0d] got %02h want %02h", i, q4[i], exp_q[i]); end
    end
    vectors++; if (ov4 !== 1'b0) begin errors++; $display("FAIL line_out_valid_after got %b want 0", ov4); end
    vectors++; if (t1 - t0 != 3) begin errors++; $display("FAIL line_byte_period got %0d want 3", t1 - t0); end
    vectors++; if (t2 - t1 != 3) begin errors++; $display("FAIL line_byte_period2 got %0d want 3", t2 - t1); end
  endtask

  task automatic test_last();
    int t;
    apply_reset();
    out_ready = 1'b1;
    send(0, 8'h11, 0, t);
    send(0, 8'h3C, 1, t);
    send(0, 8'h01, 0, t);
    send(0, 8'h02, 0, t);
    send(0, 8'h03, 0, t);
    send(0, 8'h04, 0, t);
    wait_idle(0);
    exp_q = '{8'h31, 8'h31, 8'h33, 8'h43, 8'h0D, 8'h0A,
              8'h30, 8'h31, 8'h30, 8'h32, 8'h30, 8'h33, 8'h30, 8'h34, 8'h0D, 8'h0A};
    vectors++;
    if (q4.size() != exp_q.size()) begin errors++; $display("FAIL last_len got %0d want %0d", q4.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q4.size(); i++) begin
      vectors++;
      if (q4[i] !== exp_q[i]) begin errors++; $display("FAIL last_char[%0d] got %02h want %02h", i, q4[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int t;
    apply_reset();
    out_ready = 1'b0;
    send(0, 8'hA5, 0, t);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (ov4 !== 1'b1 || od4 !== 8'h41 || ir4 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%02h r=%b want v=1 d=41 r=0", i, ov4, od4, ir4);
      end
      @(posedge comm_clock); #1;
    end
    out_ready = 1'b1;
    @(posedge comm_clock); #1;
    vectors++;
    if (ov4 !== 1'b1 || od4 !== 8'h35) begin errors++; $display("FAIL bp_next got v=%b d=%02h want v=1 d=35", ov4, od4); end
    send(0, 8'h00, 1, t);
    wait_idle(0);
    exp_q = '{8'h41, 8'h35, 8'h30, 8'h30, 8'h0D, 8'h0A};
    vectors++;
    if (q4.size() != exp_q.size()) begin errors++; $display("FAIL bp_len got %0d want %0d", q4.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q4.size(); i++) begin
      vectors++;
      if (q4[i] !== exp_q[i]) begin errors++; $display("FAIL bp_char[%0d] got %02h want %02h", i, q4[i], exp_q[i]); end
    end
  endtask

  task automatic test_ignore_inputs();
    int n;
    apply_reset();
    out_ready = 1'b1;
    in_data = 8'h5A;
    in_last = 1'b1;
    iv4 = 1'b1;
    @(posedge comm_clock); #1;
    n = 0;
    while (!ir4 && n < 50) begin
      in_data = 8'(8'h80 + n * 8'h13);
      in_last = 1'b0;
      @(posedge comm_clock); #1;
      n++;
    end
    vectors++; if (n != 4) begin errors++; $display("FAIL ign_busy_cycles got %0d want 4", n); end
    in_data = 8'h12;
    in_last = 1'b1;
    @(posedge comm_clock); #1;
    iv4 = 1'b0;
    in_last = 1'b0;
    wait_idle(0);
    exp_q = '{8'h35, 8'h41, 8'h0D, 8'h0A, 8'h31, 8'h32, 8'h0D, 8'h0A};
    vectors++;
    if (q4.size() != exp_q.size()) begin errors++; $display("FAIL ign_len got %0d want %0d", q4.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q4.size(); i++) begin
      vectors++;
      if (q4[i] !== exp_q[i]) begin errors++; $display("FAIL ign_char[%0d] got %02h want %02h", i, q4[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midline();
    int t;
    apply_reset();
    out_ready = 1'b1;
    send(0, 8'h11, 0, t);
    send(0, 8'h22, 0, t);
    wait_idle(0);
    out_ready = 1'b0;
    send(0, 8'h33, 0, t);
    out_ready = 1'b1;
    @(posedge comm_clock); #1;
    out_ready = 1'b0;
    vectors++;
    if (ov4 !== 1'b1 || od4 !== 8'h33) begin errors++; $display("FAIL mid_in_lo got v=%b d=%02h want v=1 d=33", ov4, od4); end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (ov4 !== 1'b0 || ir4 !== 1'b0 || od4 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got v=%b r=%b d=%02h want v=0 r=0 d=00", ov4, ir4, od4);
    end
    @(posedge comm_clock); #1;
    reset = 1'b0;
    @(posedge comm_clock); #1;
    q4.delete();
    out_ready = 1'b1;
    send(0, 8'h44, 0, t);
    send(0, 8'h55, 0, t);
    send(0, 8'h66, 0, t);
    send(0, 8'h77, 0, t);
    wait_idle(0);
    exp_q = '{8'h34, 8'h34, 8'h35, 8'h35, 8'h36, 8'h36, 8'h37, 8'h37, 8'h0D, 8'h0A};
    vectors++;
    if (q4.size() != exp_q.size()) begin errors++; $display("FAIL mid_len got %0d want %0d", q4.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q4.size(); i++) begin
      vectors++;
      if (q4[i] !== exp_q[i]) begin errors++; $display("FAIL mid_char[%0d] got %02h want %02h", i, q4[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back_bpl1();
    int t0, t1;
    apply_reset();
    out_ready = 1'b1;
    send(1, 8'h00, 0, t0);
    send(1, 8'hFF, 0, t1);
    wait_idle(1);
    exp_q = '{8'h30, 8'h30, 8'h0D, 8'h0A, 8'h46, 8'h46, 8'h0D, 8'h0A};
    vectors++;
    if (q1.size() != exp_q.size()) begin errors++; $display("FAIL bpl1_len got %0d want %0d", q1.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q1.size(); i++) begin
      vectors++;
      if (q1[i] !== exp_q[i]) begin errors++; $display("FAIL bpl1_char[%0d] got %02h want %02h", i, q1[i], exp_q[i]); end
    end
    vectors++; if (t1 - t0 != 5) begin errors++; $display("FAIL bpl1_byte_period got %0d want 5", t1 - t0); end
  endtask

  initial begin
    reset     = 1'b1;
    iv4       = 1'b0;
    iv1       = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_line();
    test_last();
    test_backpressure();
    test_ignore_inputs();
    test_reset_midline();
    test_back_to_back_bpl1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
